// File: rtl/adc_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// adc_scan_ctrl_if
// Read-request handshake between the ADC scan scheduler and the shared I2C
// read engine. The scheduler is the master: it raises rd_req/reg_addr_vld
// for one cycle with a register address. The engine, as the slave, answers
// later with a one-cycle rd_data_vld carrying rd_data.
// ----------------------------------------------------------------------------
interface adc_scan_ctrl_if;
    logic       rd_req;
    logic [6:0] device_id;
    logic [7:0] reg_addr;
    logic       reg_addr_vld;
    logic [7:0] rd_data;
    logic       rd_data_vld;

    // Scheduler side
    modport master (
        output rd_req,
        output device_id,
        output reg_addr,
        output reg_addr_vld,
        input  rd_data,
        input  rd_data_vld
    );

    // I2C read engine side
    modport slave (
        input  rd_req,
        input  device_id,
        input  reg_addr,
        input  reg_addr_vld,
        output rd_data,
        output rd_data_vld
    );
endinterface : adc_scan_ctrl_if

// File: rtl/adc_scan_ctrl.sv
// ----------------------------------------------------------------------------
// adc_scan_ctrl
// Periodic scan scheduler for the shared I2C ADC read engine.
//  - A free-running tick generator fires once every CLK_FREQ/SAMPLE_HZ cycles.
//  - On a tick the FSM performs one read for each channel enabled in ch_mask.
//    It walks the channels in ascending order and keeps one request
//    outstanding at a time.
//  - A read that gets no answer within TIMEOUT_CYC cycles is abandoned. This
//    sets a sticky err_timeout flag and leaves the channel result unchanged.
//  - A tick that lands while a scan is still running is dropped and sets the
//    sticky err_overrun flag.
//
// Build option:
//  ADC_AVG_EN  when defined, each channel averages four accepted samples
//              before it publishes a result (floor of sum/4). When
//              undefined, every accepted sample is published directly.
// ----------------------------------------------------------------------------
module adc_scan_ctrl #(
    parameter int         CLK_FREQ    = 50_000_000,
    parameter int         SAMPLE_HZ   = 1000,
    parameter logic [6:0] DEVICE_ID   = 7'b101_0100,
    parameter logic [7:0] REG_BASE    = 8'h00,
    parameter int         TIMEOUT_CYC = 100_000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    adc_scan_ctrl_if.master        eng_if,
    input  logic                   i_scan_en,
    input  logic [3:0]             i_ch_mask,
    input  logic                   i_err_clr,
    output logic [31:0]            o_ch_data,
    output logic                   o_sample_vld,
    output logic [1:0]             o_sample_ch,
    output logic                   o_scan_done,
    output logic                   o_err_timeout,
    output logic                   o_err_overrun
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int PERIOD_RAW = CLK_FREQ / SAMPLE_HZ;
    localparam int PERIOD     = (PERIOD_RAW < 1) ? 1 : PERIOD_RAW;
    localparam int TICK_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TO_LIMIT   = (TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC;
    localparam int TO_W       = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);

    // FSM encoding
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT_VLD = 3'd2;
    localparam logic [2:0] S_STORE    = 3'd3;
    localparam logic [2:0] S_NEXT     = 3'd4;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    logic [2:0]        r_state;
    logic [3:0]        r_scan_mask;
    logic [1:0]        r_cur_ch;
    logic [7:0]        r_reg_addr;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_scan_done;

    logic              r_sample_vld;
    logic [1:0]        r_sample_ch;
    logic              r_err_timeout;
    logic              r_err_overrun;

    logic [1:0]        w_first_ch;
    logic              w_next_found;
    logic [1:0]        w_next_ch;
    logic              w_start;
    logic              w_accept;
    logic              w_to_expire;
    logic              w_overrun_set;
    logic [3:0]        w_pub;
    logic              w_publish;

    // ------------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Free-running sample-period counter; it keeps running while scanning is disabled
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Channel selection
    // ------------------------------------------------------------------------
    // Lowest set bit of the live mask picks the first channel of a new scan
    always_comb begin
        w_first_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (i_ch_mask[i]) begin
                w_first_ch = 2'(i);
            end
        end
    end

    // Lowest set bit of the latched mask above the current channel
    always_comb begin
        w_next_found = 1'b0;
        w_next_ch    = r_cur_ch;
        for (int i = 3; i >= 0; i--) begin
            if (r_scan_mask[i] && (2'(i) > r_cur_ch)) begin
                w_next_found = 1'b1;
                w_next_ch    = 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control events
    // ------------------------------------------------------------------------
    assign w_start       = (r_state == S_IDLE) && w_tick && i_scan_en && (i_ch_mask != 4'd0);
    // Data on the terminal timeout cycle still wins over the timeout
    assign w_accept      = (r_state == S_WAIT_VLD) && eng_if.rd_data_vld;
    assign w_to_expire   = (r_state == S_WAIT_VLD) && !eng_if.rd_data_vld && (r_to_cnt == TO_LAST);
    assign w_overrun_set = w_tick && (r_state != S_IDLE);

    // ------------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------------
    // Scan FSM: one request per enabled channel, never more than one in flight
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_scan_mask <= 4'd0;
            r_cur_ch    <= 2'd0;
            r_reg_addr  <= 8'd0;
            r_to_cnt    <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The mask is frozen here so mid-scan edits wait for the next scan
                    if (w_start) begin
                        r_scan_mask <= i_ch_mask;
                        r_cur_ch    <= w_first_ch;
                        r_reg_addr  <= REG_BASE + {6'd0, w_first_ch};
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT_VLD;
                end
                S_WAIT_VLD: begin
                    if (w_accept) begin
                        r_state <= S_STORE;
                    end else if (w_to_expire) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_STORE: begin
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    // Disabling only takes effect between channels, so a request is never abandoned
                    if (!i_scan_en) begin
                        r_state <= S_IDLE;
                    end else if (w_next_found) begin
                        r_cur_ch   <= w_next_ch;
                        r_reg_addr <= REG_BASE + {6'd0, w_next_ch};
                        r_state    <= S_ISSUE;
                    end else begin
                        r_scan_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel result storage
    // The result field is written on the same edge that accepts rd_data. The
    // new value is therefore already visible in the STORE cycle, together
    // with the sample_vld pulse.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [7:0] r_field;
        logic       w_sel;

        assign w_sel = w_accept && (r_cur_ch == 2'(gi));

`ifdef ADC_AVG_EN
        logic [9:0] r_acc;
        logic [1:0] r_cnt;
        logic [9:0] w_sum;

        // Four 8-bit samples sum to at most 1020, so 10 bits never overflow
        assign w_sum       = r_acc + {2'b00, eng_if.rd_data};
        assign w_pub[gi]   = w_sel && (r_cnt == 2'd3);

        // Accumulate three samples and publish the floored mean on the fourth
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_field <= 8'd0;
                r_acc   <= 10'd0;
                r_cnt   <= 2'd0;
            end else if (w_sel) begin
                if (r_cnt == 2'd3) begin
                    r_field <= w_sum[9:2];
                    r_acc   <= 10'd0;
                    r_cnt   <= 2'd0;
                end else begin
                    r_acc   <= w_sum;
                    r_cnt   <= r_cnt + 2'd1;
                end
            end
        end
`else
        assign w_pub[gi] = w_sel;

        // Publish every accepted sample directly
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_field <= 8'd0;
            end else if (w_sel) begin
                r_field <= eng_if.rd_data;
            end
        end
`endif

        assign o_ch_data[8*gi +: 8] = r_field;
    end

    assign w_publish = |w_pub;

    // Update strobe and channel tag for downstream consumers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sample_vld <= 1'b0;
            r_sample_ch  <= 2'd0;
        end else begin
            r_sample_vld <= w_publish;
            if (w_publish) begin
                r_sample_ch <= r_cur_ch;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
    // A set event outranks a clear arriving in the same cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_to_expire) begin
                r_err_timeout <= 1'b1;
            end else if (i_err_clr) begin
                r_err_timeout <= 1'b0;
            end
            if (w_overrun_set) begin
                r_err_overrun <= 1'b1;
            end else if (i_err_clr) begin
                r_err_overrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign eng_if.rd_req       = (r_state == S_ISSUE);
    assign eng_if.reg_addr_vld = (r_state == S_ISSUE);
    assign eng_if.reg_addr     = r_reg_addr;
    assign eng_if.device_id    = DEVICE_ID;

    assign o_sample_vld  = r_sample_vld;
    assign o_sample_ch   = r_sample_ch;
    assign o_scan_done   = r_scan_done;
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;

endmodule : adc_scan_ctrl
